// File: rtl/icetap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icetap_capture_ctrl
// Description : Capture sequencer for the icetap logic analyzer. Streams
//               samples into a circular capture RAM once armed, detects a
//               masked-value trigger, stores a programmable number of
//               post-trigger samples, then stops and reports the trigger
//               address for readout.
// Revision    : 1.0 - initial release
// ============================================================================
module icetap_capture_ctrl #(
    parameter int NR_SIGNALS = 8,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_arm,
    input  logic                  cmd_abort,
    input  logic [NR_SIGNALS-1:0] cfg_trig_mask,
    input  logic [NR_SIGNALS-1:0] cfg_trig_value,
    input  logic [ADDR_BITS-1:0]  cfg_post_count,
    input  logic [NR_SIGNALS-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  mem_wr,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [NR_SIGNALS-1:0] mem_wdata,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic                  wrapped,
    output logic [ADDR_BITS-1:0]  trig_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_BITS-1:0] c_ptr_max = '1;

    state_t                  r_state,     w_state_nxt;
    logic [ADDR_BITS-1:0]    r_wr_ptr,    w_wr_ptr_nxt;
    logic [ADDR_BITS-1:0]    r_post_cnt,  w_post_cnt_nxt;
    logic [NR_SIGNALS-1:0]   r_mask,      w_mask_nxt;
    logic [NR_SIGNALS-1:0]   r_value,     w_value_nxt;
    logic [ADDR_BITS-1:0]    r_post_cfg,  w_post_cfg_nxt;
    logic                    r_mem_wr,    w_mem_wr_nxt;
    logic [ADDR_BITS-1:0]    r_mem_addr,  w_mem_addr_nxt;
    logic [NR_SIGNALS-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                    r_triggered, w_triggered_nxt;
    logic                    r_wrapped,   w_wrapped_nxt;
    logic [ADDR_BITS-1:0]    r_trig_addr, w_trig_addr_nxt;

    logic                    w_capturing;
    logic                    w_write;
    logic                    w_hit;

    // Sample is stored only while capturing, and an abort drops that cycle's sample
    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_write     = w_capturing && sample_valid && !cmd_abort;
    assign w_hit       = ((sample_in ^ r_value) & r_mask) == '0;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_post_cnt  <= '0;
            r_mask      <= '0;
            r_value     <= '0;
            r_post_cfg  <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_triggered <= 1'b0;
            r_wrapped   <= 1'b0;
            r_trig_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_post_cnt  <= w_post_cnt_nxt;
            r_mask      <= w_mask_nxt;
            r_value     <= w_value_nxt;
            r_post_cfg  <= w_post_cfg_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_triggered <= w_triggered_nxt;
            r_wrapped   <= w_wrapped_nxt;
            r_trig_addr <= w_trig_addr_nxt;
        end
    end

    // Next-state and next-output decode for the capture sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_post_cnt_nxt  = r_post_cnt;
        w_mask_nxt      = r_mask;
        w_value_nxt     = r_value;
        w_post_cfg_nxt  = r_post_cfg;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_triggered_nxt = r_triggered;
        w_wrapped_nxt   = r_wrapped;
        w_trig_addr_nxt = r_trig_addr;

        // Common write path shared by ARMED and POST
        if (w_write) begin
            w_mem_wr_nxt    = 1'b1;
            w_mem_addr_nxt  = r_wr_ptr;
            w_mem_wdata_nxt = sample_in;
            w_wr_ptr_nxt    = r_wr_ptr + 1'b1;
            if (r_wr_ptr == c_ptr_max) begin
                w_wrapped_nxt = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (cmd_arm) begin
                    // Configuration is frozen here for the whole capture
                    w_state_nxt     = ST_ARMED;
                    w_wr_ptr_nxt    = '0;
                    w_triggered_nxt = 1'b0;
                    w_wrapped_nxt   = 1'b0;
                    w_mask_nxt      = cfg_trig_mask;
                    w_value_nxt     = cfg_trig_value;
                    w_post_cfg_nxt  = cfg_post_count;
                end
            end
            ST_ARMED: begin
                if (cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (sample_valid && w_hit) begin
                    w_trig_addr_nxt = r_wr_ptr;
                    w_triggered_nxt = 1'b1;
                    w_post_cnt_nxt  = r_post_cfg;
                    w_state_nxt     = (r_post_cfg == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (cmd_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (sample_valid) begin
                    w_post_cnt_nxt = r_post_cnt - 1'b1;
                    if (r_post_cnt == {{(ADDR_BITS-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign state     = r_state;
    assign triggered = r_triggered;
    assign wrapped   = r_wrapped;
    assign trig_addr = r_trig_addr;

endmodule
`default_nettype wire

// File: tb/tb_icetap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icetap_capture_ctrl
// Description : Self-checking bench for icetap_capture_ctrl: directed capture
//               scenarios followed by randomized traffic, all compared every
//               cycle against a behavioural capture model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icetap_capture_ctrl;

    localparam int NS    = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_arm = 1'b0;
    logic          cmd_abort = 1'b0;
    logic [NS-1:0] cfg_trig_mask = '0;
    logic [NS-1:0] cfg_trig_value = '0;
    logic [AB-1:0] cfg_post_count = '0;
    logic [NS-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          mem_wr;
    logic [AB-1:0] mem_addr;
    logic [NS-1:0] mem_wdata;
    logic [1:0]    state;
    logic          triggered;
    logic          wrapped;
    logic [AB-1:0] trig_addr;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;

    // Behavioural model: state as 0..3, pointer as a plain integer
    int            m_state = 0;
    int            m_ptr = 0;
    int            m_taddr = 0;
    int            m_after = 0;
    int            m_post = 0;
    int            m_addr = 0;
    bit            m_trig = 0;
    bit            m_wrap = 0;
    bit            m_wr = 0;
    logic [NS-1:0] m_mask = '0;
    logic [NS-1:0] m_value = '0;
    logic [NS-1:0] m_data = '0;

    icetap_capture_ctrl #(
        .NR_SIGNALS (NS),
        .ADDR_BITS  (AB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_arm        (cmd_arm),
        .cmd_abort      (cmd_abort),
        .cfg_trig_mask  (cfg_trig_mask),
        .cfg_trig_value (cfg_trig_value),
        .cfg_post_count (cfg_post_count),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .state          (state),
        .triggered      (triggered),
        .wrapped        (wrapped),
        .trig_addr      (trig_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input logic [NS-1:0] s);
        m_wr   = 1;
        m_addr = m_ptr;
        m_data = s;
        m_ptr  = (m_ptr + 1) % DEPTH;
        if (m_ptr == 0) m_wrap = 1;
    endtask

    // One clock edge of the capture rules
    task automatic model_edge(input bit r, input bit a, input bit ab, input bit v, input logic [NS-1:0] s);
        m_wr = 0;
        if (r) begin
            m_state = 0; m_ptr = 0; m_taddr = 0; m_after = 0; m_post = 0;
            m_addr = 0; m_data = '0; m_trig = 0; m_wrap = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (ab) m_state = 0;
            else if (a) begin
                m_state = 1; m_ptr = 0; m_trig = 0; m_wrap = 0;
                m_mask = cfg_trig_mask; m_value = cfg_trig_value;
                m_post = int'(cfg_post_count);
            end
        end else if (ab) begin
            m_state = 0;
        end else if (v) begin
            model_store(s);
            if (m_state == 1) begin
                if (((s ^ m_value) & m_mask) == 0) begin
                    m_trig = 1; m_taddr = m_addr; m_after = 0;
                    m_state = (m_post == 0) ? 3 : 2;
                end
            end else begin
                m_after++;
                if (m_after == m_post) m_state = 3;
            end
        end
    endtask

    task automatic step(input bit r, input bit a, input bit ab, input bit v, input logic [NS-1:0] s);
        reset = r; cmd_arm = a; cmd_abort = ab; sample_valid = v; sample_in = s;
        @(posedge clk);
        model_edge(r, a, ab, v, s);
        #1;
        if (mem_wr === 1'b1) writes_seen++;
        check("state",     32'(state),     32'(m_state));
        check("triggered", 32'(triggered), 32'(m_trig));
        check("wrapped",   32'(wrapped),   32'(m_wrap));
        check("trig_addr", 32'(trig_addr), 32'(m_taddr));
        check("mem_wr",    32'(mem_wr),    32'(m_wr));
        if (m_wr) begin
            check("mem_addr",  32'(mem_addr),  32'(m_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_data));
        end
    endtask

    task automatic arm(input logic [NS-1:0] mk, input logic [NS-1:0] vl, input logic [AB-1:0] pc);
        cfg_trig_mask = mk; cfg_trig_value = vl; cfg_post_count = pc;
        step(0, 1, 0, 0, '0);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        bit r, a, ab, v;

        // Reset values
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 1, 8'h12);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);

        // Basic trigger: samples 0..9, trigger on 5, three post samples
        arm(8'hFF, 8'h05, 4'd3);
        writes_seen = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'(i));
        check("basic_writes",    32'(writes_seen), 32'd9);
        check("basic_trig_addr", 32'(trig_addr),   32'd5);
        check("basic_state",     32'(state),       32'd3);

        // Wrap: 20 misses, trigger, two more
        arm(8'hFF, 8'hAA, 4'd2);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 8'(i));
        step(0, 0, 0, 1, 8'hAA);
        step(0, 0, 0, 1, 8'h01);
        step(0, 0, 0, 1, 8'h02);
        check("wrap_wrapped",   32'(wrapped),   32'd1);
        check("wrap_trig_addr", 32'(trig_addr), 32'd4);
        check("wrap_last_addr", 32'(mem_addr),  32'd6);
        check("wrap_state",     32'(state),     32'd3);

        // Masked compare on the low nibble
        arm(8'h0F, 8'h03, 4'd0);
        step(0, 0, 0, 1, 8'hF2);
        check("mask_miss", 32'(triggered), 32'd0);
        step(0, 0, 0, 1, 8'hF3);
        check("mask_hit",  32'(triggered), 32'd1);
        check("mask_done", 32'(state),     32'd3);

        // Mask zero, post zero: first valid sample triggers
        arm(8'h00, 8'h00, 4'd0);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h77);
        check("imm_wr",    32'(mem_wr),   32'd1);
        check("imm_addr",  32'(mem_addr), 32'd0);
        check("imm_state", 32'(state),    32'd3);

        // Gapped valids during POST
        arm(8'hFF, 8'h10, 4'd4);
        step(0, 0, 0, 1, 8'h10);
        writes_seen = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, 8'(8'h20 + i));
        step(0, 0, 0, 1, 8'h99);
        check("gap_writes", 32'(writes_seen), 32'd4);
        check("gap_state",  32'(state),       32'd3);

        // Abort beats a matching sample
        arm(8'hFF, 8'h33, 4'd2);
        step(0, 0, 1, 1, 8'h33);
        check("abort_wr",    32'(mem_wr),    32'd0);
        check("abort_trig",  32'(triggered), 32'd0);
        check("abort_state", 32'(state),     32'd0);

        // Arm during POST ignored; arm+abort in DONE goes idle
        arm(8'hFF, 8'h44, 4'd3);
        step(0, 0, 0, 1, 8'h44);
        step(0, 1, 0, 1, 8'h01);
        check("post_arm_state", 32'(state), 32'd2);
        step(0, 0, 0, 1, 8'h02);
        step(0, 0, 0, 1, 8'h03);
        check("post_done", 32'(state), 32'd3);
        step(0, 1, 1, 0, 8'h00);
        check("arm_abort_idle", 32'(state), 32'd0);

        // Reset in POST, then a fresh capture starts at address 0
        arm(8'hFF, 8'h55, 4'd5);
        step(0, 0, 0, 1, 8'h55);
        step(0, 0, 0, 1, 8'h01);
        step(1, 0, 0, 1, 8'h02);
        check("rstpost_wr",    32'(mem_wr),    32'd0);
        check("rstpost_addr",  32'(mem_addr),  32'd0);
        check("rstpost_data",  32'(mem_wdata), 32'd0);
        check("rstpost_state", 32'(state),     32'd0);
        check("rstpost_trig",  32'(triggered), 32'd0);
        check("rstpost_taddr", 32'(trig_addr), 32'd0);
        writes_seen = 0;
        step(0, 0, 0, 1, 8'h03);
        check("rstpost_nowr", 32'(writes_seen), 32'd0);
        arm(8'hFF, 8'h66, 4'd1);
        step(0, 0, 0, 1, 8'h09);
        check("rearm_addr", 32'(mem_addr), 32'd0);
        check("rearm_wr",   32'(mem_wr),   32'd1);

        // Randomized traffic with config churn after arm
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            a  = ($urandom_range(0, 39) == 0);
            ab = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (a || $urandom_range(0, 9) == 0) begin
                cfg_trig_mask  = 8'($urandom) & 8'h07;
                cfg_trig_value = 8'($urandom);
                cfg_post_count = 4'($urandom);
            end
            step(r, a, ab, v, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Capture sequencer for the icetap logic analyzer. Sits between the scan-clock sample source and the capture RAM. Arms on command, streams samples into a circular buffer, detects a masked-value trigger, records a programmable number of post-trigger samples, then stops and reports the trigger address for SPI readout.

## Interface

Parameters:
- NR_SIGNALS, 8: sample width in bits.
- ADDR_BITS, 9: capture RAM address width; buffer depth is 2^ADDR_BITS.

Ports:
- clk  in  1  scan clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_arm  in  1  single-cycle pulse: start a capture.
- cmd_abort  in  1  single-cycle pulse: cancel the capture and return to IDLE.
- cfg_trig_mask  in  NR_SIGNALS  bit=1 means the bit participates in the trigger compare.
- cfg_trig_value  in  NR_SIGNALS  trigger compare value.
- cfg_post_count  in  ADDR_BITS  number of samples stored after the trigger sample.
- sample_in  in  NR_SIGNALS  probe data.
- sample_valid  in  1  sample_in is valid this cycle.
- mem_wr  out  1  capture RAM write strobe.
- mem_addr  out  ADDR_BITS  capture RAM write address.
- mem_wdata  out  NR_SIGNALS  capture RAM write data.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- triggered  out  1  trigger seen in the current or last capture.
- wrapped  out  1  buffer write pointer has wrapped at least once.
- trig_addr  out  ADDR_BITS  address that holds the trigger sample.

## Operation

- All outputs are registered. Reset values: state=IDLE; mem_wr, triggered and wrapped are 0; mem_addr, mem_wdata and trig_addr are 0. The internal write pointer (wr_ptr) and post counter are also 0.
- cfg_* inputs are latched on the cmd_arm cycle. Later changes do not affect a running capture.
- IDLE:
  - No writes.
  - cmd_arm moves to ARMED and clears wr_ptr, triggered and wrapped.
- ARMED:
  - Every sample_valid writes sample_in at wr_ptr. wr_ptr then increments modulo 2^ADDR_BITS.
  - wrapped sets when wr_ptr goes from 2^ADDR_BITS-1 to 0. It stays set until the next arm.
  - Trigger condition: sample_valid and ((sample_in ^ value) & mask) == 0. A mask of 0 triggers on the first valid sample.
  - On trigger:
    - The trigger sample is still written.
    - trig_addr takes wr_ptr, triggered sets and the post counter loads cfg_post_count.
    - Next state is POST, or DONE if cfg_post_count==0.
- POST:
  - Every sample_valid writes and decrements the post counter. The trigger compare is ignored.
  - The write that brings the counter to 0 also moves to DONE.
  - Exactly cfg_post_count samples follow the trigger sample.
  - cfg_post_count = 2^ADDR_BITS-1 fills the buffer exactly once without overwriting the trigger sample.
- DONE:
  - No writes. Outputs hold for readout.
  - cmd_arm re-arms, with the same clears as from IDLE.
  - cmd_abort goes to IDLE and leaves triggered, wrapped and trig_addr unchanged.
- cmd_abort in ARMED or POST goes to IDLE on the next edge.
  - Abort has priority over sample_valid and over the trigger; that cycle's sample is not written.
  - triggered, wrapped and trig_addr hold their current values.
- cmd_arm outside IDLE/DONE is ignored. If cmd_arm and cmd_abort arrive together, abort wins.
- Readout logic finds the oldest sample at wr_ptr when wrapped=1, otherwise at 0.

## Timing

- Write latency is 1 cycle. A sample_valid on edge N gives mem_wr=1 with the matching mem_addr and mem_wdata during cycle N+1. mem_wr is a single-cycle pulse per sample.
- state, triggered, trig_addr and wrapped update on the same edge as the corresponding write.
- Arm latency is 1 cycle. The first sample that can be captured is the one valid on the edge after the cmd_arm edge.
- Back-to-back sample_valid at full clock rate is supported, with no stalls.
- Reset mid-capture: on the next edge, all outputs return to their reset values and no write is issued.

## Test plan

- Basic trigger:
  - Stimulus: arm with mask=0xFF, value=0x05, post=3; then feed the samples 0x00..0x09 on consecutive cycles.
  - Required response: 9 writes, of values 0x00..0x08 at addresses 0..8. trig_addr=5, triggered=1, state=DONE one cycle after the write of 0x08.
- Wrap:
  - Stimulus: ADDR_BITS=4, arm with mask=0xFF, value=0xAA, post=2; feed 20 non-matching samples, then 0xAA, then 2 more samples.
  - Required response: wrapped=1, trig_addr=4 (20 mod 16), last write at address 6, state=DONE.
- Masked and immediate:
  - Case 1: arm with mask=0x0F, value=0x03. Sample 0xF3 triggers; sample 0xF2 does not.
  - Case 2: mask=0 and post=0. The first valid sample is written at address 0 and state goes straight to DONE.
- Gaps:
  - Stimulus: sample_valid toggling 1/0 during POST with post=4.
  - Required response: exactly 4 post-trigger writes; no writes on cycles with sample_valid=0.
- Abort and priority:
  - Stimulus: cmd_abort on the same cycle as a matching sample.
  - Required response: no write, triggered stays 0, state goes to IDLE.
  - A cmd_arm during POST has no effect. Arm and abort together in DONE leads to IDLE.
- Reset:
  - Stimulus: assert reset during POST.
  - Required response: all outputs at reset values on the next cycle and no further writes.
  - A subsequent arm captures from address 0.
